// File: rtl/pll_seq_pkg.sv
// rtl/pll_seq_pkg.sv - shared types and helpers for the PLL reset sequencer
//
// Holds the sequencer state encoding (also exported for debug/LEDs), the
// state vector width and a constant ceil(log2) helper used to size counters.

package pll_seq_pkg;

   localparam int SEQ_STATE_W = 3;

   typedef enum logic [SEQ_STATE_W-1:0] {
      S_RESET     = 3'd0,
      S_PLL_RST   = 3'd1,
      S_WAIT_LOCK = 3'd2,
      S_STABLE    = 3'd3,
      S_RUN       = 3'd4,
      S_FAIL      = 3'd5
   } seq_state_e;

   // ceil(log2(v)); returns 0 for v <= 1, so callers clamp to a 1-bit minimum.
   function automatic int clog2(input int v);
      int r;
      int x;
      r = 0;
      x = v - 1;
      for (int i = 0; i < 32; i++) begin
         if (x > 0) begin
            r = r + 1;
            x = x >> 1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// rtl/pll_reset_sequencer_if.sv - PLL/core-facing signal bundle of the sequencer
//
// Ports (signals):
//   pll_locked  PLL lock indication, asynchronous to refclk
//   pll_rst     PLL reset, active-high
//   sys_rst_n   core reset, active-low
//   seq_state   current sequencer state encoding
//   retry_cnt   PLL reset retries consumed
//   lock_fail   sticky: the PLL never locked
//   lock_lost   one-cycle pulse on loss of lock while running
// Modports: master = sequencer side, slave = PLL/core side.

interface pll_reset_sequencer_if #(
   parameter int MAX_RETRIES = 3
) ();

   localparam int RETRY_W = (pll_seq_pkg::clog2(MAX_RETRIES + 1) > 0) ?
                            pll_seq_pkg::clog2(MAX_RETRIES + 1) : 1;

   logic                                 pll_locked;
   logic                                 pll_rst;
   logic                                 sys_rst_n;
   logic [pll_seq_pkg::SEQ_STATE_W-1:0]  seq_state;
   logic [RETRY_W-1:0]                   retry_cnt;
   logic                                 lock_fail;
   logic                                 lock_lost;

   modport master (
      input  pll_locked,
      output pll_rst, sys_rst_n, seq_state, retry_cnt, lock_fail, lock_lost
   );

   modport slave (
      output pll_locked,
      input  pll_rst, sys_rst_n, seq_state, retry_cnt, lock_fail, lock_lost
   );

endinterface

// File: rtl/pll_reset_sequencer_sync_2ff.sv
// rtl/pll_reset_sequencer_sync_2ff.sv - 1-bit two-flop synchroniser
//
// Ports:
//   clk    destination clock
//   rst_n  synchronous active-low reset, both stages clear to 0
//   d      asynchronous input
//   q      synchronised output, two clk cycles of latency

module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL reset, lock qualification and core reset release
//
// Pulses the PLL reset, waits for lock with timeout and bounded retries,
// requires lock to hold for a stable window, then releases the core reset.
// Runs on the free-running reference clock.
//
// Ports:
//   refclk  reference clock
//   rst_n   synchronous active-low reset
//   bus     pll_reset_sequencer_if.master (pll_locked in; pll_rst, sys_rst_n,
//           seq_state, retry_cnt, lock_fail, lock_lost out)
//
// Build option: PLL_SEQ_AUTORELOCK_EN - when defined, losing lock while
// running re-runs the full sequence (new PLL reset pulse, retries cleared);
// otherwise the sequencer falls back to waiting for lock.

module pll_reset_sequencer
   import pll_seq_pkg::*;
#(
   parameter int PLL_RST_CYCLES      = 50,
   parameter int LOCK_TIMEOUT_CYCLES = 50000,
   parameter int LOCK_STABLE_CYCLES  = 1024,
   parameter int MAX_RETRIES         = 3
) (
   input  logic                    refclk,
   input  logic                    rst_n,
   pll_reset_sequencer_if.master   bus
);

   localparam int CNT_MAX_A = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                              PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
   localparam int CNT_MAX   = (CNT_MAX_A > LOCK_STABLE_CYCLES) ?
                              CNT_MAX_A : LOCK_STABLE_CYCLES;
   localparam int CNT_W     = (clog2(CNT_MAX) > 0) ? clog2(CNT_MAX) : 1;
   localparam int RETRY_W   = (clog2(MAX_RETRIES + 1) > 0) ?
                              clog2(MAX_RETRIES + 1) : 1;

   localparam logic [CNT_W-1:0]   PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

   seq_state_e           state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [RETRY_W-1:0]   retry_q, retry_d;
   logic                 lock_fail_q, lock_fail_d;
   logic                 lock_lost_q, lock_lost_d;
   logic                 pll_rst_q, pll_rst_d;
   logic                 sys_rst_n_q, sys_rst_n_d;
   logic                 locked_s;

   sync_2ff u_lock_sync (
      .clk   (refclk),
      .rst_n (rst_n),
      .d     (bus.pll_locked),
      .q     (locked_s)
   );

   always_comb begin
      state_d     = state_q;
      retry_d     = retry_q;
      lock_fail_d = lock_fail_q;
      lock_lost_d = 1'b0;

      case (state_q)
         S_RESET: begin
            state_d = S_PLL_RST;
         end
         S_PLL_RST: begin
            if (cnt_q == PLL_RST_LAST) begin
               state_d = S_WAIT_LOCK;
            end
         end
         S_WAIT_LOCK: begin
            // Lock is checked first so a lock arriving on the timeout cycle wins.
            if (locked_s) begin
               state_d = S_STABLE;
            end else if (cnt_q == TIMEOUT_LAST) begin
               if (retry_q == RETRY_LIMIT) begin
                  state_d = S_FAIL;
               end else begin
                  retry_d = retry_q + RETRY_W'(1);
                  state_d = S_PLL_RST;
               end
            end
         end
         S_STABLE: begin
            if (!locked_s) begin
               state_d = S_WAIT_LOCK;
            end else if (cnt_q == STABLE_LAST) begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (!locked_s) begin
               lock_lost_d = 1'b1;
`ifdef PLL_SEQ_AUTORELOCK_EN
               state_d = S_PLL_RST;
               retry_d = '0;
`else
               state_d = S_WAIT_LOCK;
`endif
            end
         end
         S_FAIL: begin
            state_d = S_FAIL;
         end
         default: begin
            state_d = S_RESET;
         end
      endcase

      if (state_d == S_FAIL) begin
         lock_fail_d = 1'b1;
      end

      // Counter restarts on every state entry and idles in states that do not time.
      if (state_d != state_q) begin
         cnt_d = '0;
      end else if (state_q == S_PLL_RST || state_q == S_WAIT_LOCK ||
                   state_q == S_STABLE) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else begin
         cnt_d = '0;
      end

      // Outputs are registered from the next state so they match seq_state cycle-for-cycle.
      pll_rst_d   = (state_d == S_RESET) || (state_d == S_PLL_RST) ||
                    (state_d == S_FAIL);
      sys_rst_n_d = (state_d == S_RUN);
   end

   always_ff @(posedge refclk) begin
      if (!rst_n) begin
         state_q     <= S_RESET;
         cnt_q       <= '0;
         retry_q     <= '0;
         lock_fail_q <= 1'b0;
         lock_lost_q <= 1'b0;
         pll_rst_q   <= 1'b1;
         sys_rst_n_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         retry_q     <= retry_d;
         lock_fail_q <= lock_fail_d;
         lock_lost_q <= lock_lost_d;
         pll_rst_q   <= pll_rst_d;
         sys_rst_n_q <= sys_rst_n_d;
      end
   end

   assign bus.pll_rst   = pll_rst_q;
   assign bus.sys_rst_n = sys_rst_n_q;
   assign bus.seq_state = state_q;
   assign bus.retry_cnt = retry_q;
   assign bus.lock_fail = lock_fail_q;
   assign bus.lock_lost = lock_lost_q;

endmodule
